// File: rtl/lut_logic_pkg.sv
// lut_logic_pkg
//   Shared types and helpers for the LUT logic unit.
//   - load_state_e : serial table loader states
//   - TOTAL_BITS   : total truth-table bits for n_ch functions of n_in inputs
//   - MAX_N_IN / MAX_N_CH : legal upper bounds of the unit's parameters
package lut_logic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  localparam int MAX_N_IN = 6;
  localparam int MAX_N_CH = 8;

  function automatic int TOTAL_BITS(input int n_in, input int n_ch);
    return n_ch * (1 << n_in);
  endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader
//   Serial truth-table loader. Bits are shifted into a shadow store in flat
//   order (channel 0 minterm 0 first); on the last bit the complete table,
//   including that bit, is presented on commit_tbl together with a commit
//   strobe so the owner of the active table can copy it on the same edge.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no load in progress; cfg_valid ignored
//   LOAD  | accepting cfg_bit on cfg_valid; cfg_start restarts at index 0
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   cfg_start      : begin or restart a load (wins over cfg_valid)
//   cfg_valid      : cfg_bit valid this cycle
//   cfg_bit        : serial table bit
//   commit         : combinational strobe, last bit being written this cycle
//   commit_tbl     : shadow table with the current bit merged in
//   cfg_done       : registered one-cycle pulse after a commit
module lut_cfg_loader
  import lut_logic_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  output logic                       commit,
  output logic [N_CH*(2**N_IN)-1:0]  commit_tbl,
  output logic                       cfg_done
);

  localparam int TOTAL = TOTAL_BITS(N_IN, N_CH);
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  load_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [TOTAL-1:0] shadow;
  logic             bit_wr;

  assign bit_wr = (state == LOAD) && cfg_valid && !cfg_start;
  assign commit = bit_wr && (cnt == LAST_IDX);

  // The final bit is not yet in the shadow register when the commit edge
  // arrives, so merge it here.
  always_comb begin
    commit_tbl      = shadow;
    commit_tbl[cnt] = cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= commit;
      if (cfg_start) begin
        state <= LOAD;
        cnt   <= '0;
      end else if (bit_wr) begin
        shadow[cnt] <= cfg_bit;
        if (cnt == LAST_IDX) state <= IDLE;
        else                 cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_logic_unit.sv
// lut_logic_unit
//   N_CH independent N_IN-input Boolean functions held as runtime-loadable
//   truth tables. Tables load serially through lut_cfg_loader and are
//   committed atomically into the active table. Operands are evaluated
//   through a one-stage registered pipeline with valid/ready handshakes.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_start/valid/bit  : serial table load interface
//   cfg_done             : one-cycle pulse after a table commit
//   tbl_valid            : a committed table exists
//   in_valid/in_ready    : operand handshake; in_x is the minterm index
//   out_valid/out_ready  : result handshake; out_f[c] = channel c result
//   stats_clr, ones_cnt  : only with LUT_LOGIC_STATS_EN defined; per-channel
//                          16-bit saturating counts of 1 results delivered
module lut_logic_unit
  import lut_logic_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_done,
  output logic              tbl_valid,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH-1:0]   out_f
`ifdef LUT_LOGIC_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [N_CH*16-1:0] ones_cnt
`endif
);

  localparam int DEPTH = 2**N_IN;
  localparam int TOTAL = TOTAL_BITS(N_IN, N_CH);

  if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("lut_logic_unit: N_IN out of range 1..6");
  end
  if (N_CH < 1 || N_CH > MAX_N_CH) begin : g_bad_n_ch
    $error("lut_logic_unit: N_CH out of range 1..8");
  end

  logic                       commit;
  logic [TOTAL-1:0]           commit_tbl;
  logic [N_CH-1:0][DEPTH-1:0] active_tbl;
  logic [N_CH-1:0]            lut_out;
  logic                       accept;

  lut_cfg_loader #(
    .N_IN (N_IN),
    .N_CH (N_CH)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .commit     (commit),
    .commit_tbl (commit_tbl),
    .cfg_done   (cfg_done)
  );

  // Flat load order c*DEPTH + m maps directly onto [c][m].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_tbl <= '0;
      tbl_valid  <= 1'b0;
    end else if (commit) begin
      active_tbl <= commit_tbl;
      tbl_valid  <= 1'b1;
    end
  end

  assign in_ready = tbl_valid && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    lut_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      lut_out[c] = active_tbl[c][in_x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_f     <= lut_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_LOGIC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (stats_clr) begin
      ones_cnt <= '0;
    end else if (out_valid && out_ready) begin
      for (int c = 0; c < N_CH; c++) begin
        if (out_f[c] && (ones_cnt[c*16 +: 16] != 16'hFFFF)) begin
          ones_cnt[c*16 +: 16] <= ones_cnt[c*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_logic_unit.sv
// tb_lut_logic_unit
//   Randomised self-checking bench for lut_logic_unit (N_IN=4, N_CH=2).
//   A transaction-level model tracks the committed table, the pending result
//   and the load progress; each test compares DUT behaviour against it and
//   against hand-computed constants. Stats tests need LUT_LOGIC_STATS_EN.
module tb_lut_logic_unit;

  localparam int N_IN  = 4;
  localparam int N_CH  = 2;
  localparam int DEPTH = 16;
  localparam int TOTAL = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_bit = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [N_IN-1:0] in_x = '0;
  logic            cfg_done;
  logic            tbl_valid;
  logic            in_ready;
  logic            out_valid;
  logic [N_CH-1:0] out_f;
`ifdef LUT_LOGIC_STATS_EN
  logic            stats_clr = 1'b0;
  logic [N_CH*16-1:0] ones_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lut_logic_unit #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_done  (cfg_done),
    .tbl_valid (tbl_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f)
`ifdef LUT_LOGIC_STATS_EN
    ,
    .stats_clr (stats_clr),
    .ones_cnt  (ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [TOTAL-1:0] m_active;
  logic [TOTAL-1:0] m_shadow;
  logic             m_tbl_valid;
  logic             m_loading;
  logic             m_done_exp;
  logic             m_last_acc;
  int               m_cnt;
  logic [N_CH-1:0]  pend[$];
  logic [N_CH-1:0]  got_q[$];
  logic [N_CH-1:0]  exp_q[$];
  int               proto_bad;
  int               done_seen;

  function automatic void model_reset();
    m_active    = '0;
    m_shadow    = '0;
    m_tbl_valid = 1'b0;
    m_loading   = 1'b0;
    m_done_exp  = 1'b0;
    m_last_acc  = 1'b0;
    m_cnt       = 0;
    pend.delete();
  endfunction

  // Advance one clock, stepping the model and logging delivered results.
  task automatic tick();
    logic exp_ready;
    logic commit;
    logic [N_CH-1:0] f;
    #1;
    exp_ready = m_tbl_valid && (pend.size() == 0 || out_ready);
    if (in_ready !== exp_ready) proto_bad++;
    if (out_valid !== (pend.size() != 0)) proto_bad++;
    if (pend.size() != 0 && out_f !== pend[0]) proto_bad++;
    if (cfg_done !== m_done_exp) proto_bad++;
    if (pend.size() != 0 && out_ready) begin
      got_q.push_back(out_f);
      exp_q.push_back(pend.pop_front());
    end
    m_last_acc = in_valid && exp_ready;
    if (m_last_acc) begin
      for (int c = 0; c < N_CH; c++) f[c] = m_active[c*DEPTH + int'(in_x)];
      pend.push_back(f);
    end
    commit = 1'b0;
    if (cfg_start) begin
      m_loading = 1'b1;
      m_cnt     = 0;
    end else if (m_loading && cfg_valid) begin
      m_shadow[m_cnt] = cfg_bit;
      if (m_cnt == TOTAL - 1) begin
        commit    = 1'b1;
        m_loading = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (commit) begin
      m_active    = m_shadow;
      m_tbl_valid = 1'b1;
    end
    m_done_exp = commit;
    if (cfg_done) done_seen++;
  endtask

  task automatic drive_traffic(input int mode);
    if (mode == 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end else begin
      in_valid  = 1'($urandom_range(1));
      in_x      = N_IN'($urandom);
      out_ready = (mode == 2) ? 1'b1 : ($urandom_range(3) != 0);
    end
  endtask

  task automatic idle_ticks(input int n);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    drive_traffic(0);
    repeat (n) tick();
  endtask

  task automatic load_bits(input logic [TOTAL-1:0] bits, input int gap_pct, input int mode);
    int i;
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    drive_traffic(mode);
    tick();
    cfg_start = 1'b0;
    i = 0;
    while (i < TOTAL) begin
      drive_traffic(mode);
      if (int'($urandom_range(99)) < gap_pct) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_bit   = bits[i];
        i++;
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic eval_all();
    for (int m = 0; m < DEPTH; m++) begin
      in_valid  = 1'b1;
      in_x      = N_IN'(m);
      out_ready = 1'b1;
      tick();
    end
    idle_ticks(2);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    model_reset();
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cfg_done, tbl_valid, out_valid, out_f} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {cfg_done, tbl_valid, out_valid, out_f});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    proto_bad = 0;
    in_valid = 1'b1;
    in_x = 4'h3;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_table_accept: cycle %0d in_ready=%b out_valid=%b expected 0 0", k, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL reset_protocol: %0d deviations, expected 0", proto_bad);
    end
  endtask

  task automatic test_load_known();
    proto_bad = 0;
    done_seen = 0;
    load_bits({16'h6996, 16'h8000}, 0, 0);
    idle_ticks(2);
    checks++;
    if (done_seen !== 1 || tbl_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: done pulses %0d tbl_valid %b expected 1 1", done_seen, tbl_valid);
    end
    in_valid = 1'b1;
    in_x = 4'hF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_f !== 2'b01) begin
      errors++;
      $display("FAIL eval_xF: out_valid %b out_f %b expected 1 01", out_valid, out_f);
    end
    in_valid = 1'b1;
    in_x = 4'h1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_f !== 2'b10) begin
      errors++;
      $display("FAIL eval_x1: out_valid %b out_f %b expected 1 10", out_valid, out_f);
    end
    idle_ticks(2);
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL load_protocol: %0d deviations, expected 0", proto_bad);
    end
  endtask

  task automatic test_stream();
    logic [15:0] t0 = 16'h8000;
    logic [15:0] t1 = 16'h6996;
    logic [N_CH-1:0] held;
    int idx = 0;
    int cyc = 0;
    proto_bad = 0;
    got_q.delete();
    exp_q.delete();
    while ((idx < DEPTH || pend.size() != 0) && cyc < 100) begin
      in_valid  = (idx < DEPTH);
      in_x      = N_IN'(idx);
      out_ready = !(cyc >= 6 && cyc < 9);
      if (cyc >= 6 && cyc < 9) begin
        #1;
        if (cyc == 6) held = out_f;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_f !== held) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d in_ready=%b out_valid=%b out_f=%b expected 0 1 %b",
                   cyc, in_ready, out_valid, out_f, held);
        end
      end
      tick();
      if (m_last_acc) idx++;
      cyc++;
    end
    idle_ticks(1);
    checks++;
    if (got_q.size() !== DEPTH || cyc !== DEPTH + 4) begin
      errors++;
      $display("FAIL stream_count: results %0d cycles %0d expected %0d %0d", got_q.size(), cyc, DEPTH, DEPTH + 4);
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== {t1[i[3:0]], t0[i[3:0]]}) begin
        errors++;
        $display("FAIL stream_value: x=%0d got %b expected %b", i, got_q[i], {t1[i[3:0]], t0[i[3:0]]});
      end
    end
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL stream_protocol: %0d deviations, expected 0", proto_bad);
    end
  endtask

  task automatic test_reload_stream();
    int bad = 0;
    proto_bad = 0;
    done_seen = 0;
    got_q.delete();
    exp_q.delete();
    load_bits({16'h6996, 16'hFFFF}, 20, 2);
    for (int k = 0; k < 6; k++) begin
      drive_traffic(2);
      tick();
    end
    idle_ticks(2);
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || done_seen !== 1) begin
      errors++;
      $display("FAIL reload_stream: %0d wrong results, %0d done pulses, expected 0 1", bad, done_seen);
    end
    in_valid = 1'b1;
    in_x = 4'h0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_f !== 2'b01) begin
      errors++;
      $display("FAIL reload_new_tbl: out_f %b expected 01", out_f);
    end
    idle_ticks(1);
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL reload_protocol: %0d deviations, expected 0", proto_bad);
    end
  endtask

  task automatic test_idle_and_restart();
    logic [TOTAL-1:0] tbl_new;
    proto_bad = 0;
    done_seen = 0;
    // cfg_valid with no load running must be ignored
    for (int k = 0; k < 40; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom_range(1));
      tick();
    end
    cfg_valid = 1'b0;
    // partial load, then restart with a bit offered in the same cycle
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom_range(1));
      tick();
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL idle_partial_done: %0d done pulses expected 0", done_seen);
    end
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    tbl_new = TOTAL'($urandom);
    for (int k = 0; k < TOTAL; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = tbl_new[k];
      tick();
    end
    idle_ticks(2);
    got_q.delete();
    exp_q.delete();
    eval_all();
    checks++;
    if (done_seen !== 1 || got_q.size() !== DEPTH) begin
      errors++;
      $display("FAIL restart_done: pulses %0d results %0d expected 1 %0d", done_seen, got_q.size(), DEPTH);
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== {tbl_new[DEPTH + i], tbl_new[i]}) begin
        errors++;
        $display("FAIL restart_value: x=%0d got %b expected %b", i, got_q[i], {tbl_new[DEPTH + i], tbl_new[i]});
      end
    end
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL restart_protocol: %0d deviations, expected 0", proto_bad);
    end
  endtask

  task automatic test_random();
    int bad;
    logic [TOTAL-1:0] tbl;
    for (int it = 0; it < 4; it++) begin
      proto_bad = 0;
      bad = 0;
      got_q.delete();
      exp_q.delete();
      tbl = TOTAL'($urandom);
      load_bits(tbl, 30, 1);
      for (int k = 0; k < 20; k++) begin
        drive_traffic(1);
        tick();
      end
      idle_ticks(2);
      foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      got_q.delete();
      exp_q.delete();
      eval_all();
      foreach (got_q[i]) if (got_q[i] !== {tbl[DEPTH + i], tbl[i]}) bad++;
      checks++;
      if (bad !== 0 || proto_bad !== 0 || got_q.size() !== DEPTH) begin
        errors++;
        $display("FAIL random_iter%0d: wrong %0d deviations %0d results %0d expected 0 0 %0d",
                 it, bad, proto_bad, got_q.size(), DEPTH);
      end
    end
  endtask

  task automatic test_reset_midload();
    cfg_start = 1'b1;
    drive_traffic(1);
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom_range(1));
      in_valid  = 1'b1;
      in_x      = N_IN'($urandom);
      out_ready = 1'b0;
      tick();
    end
    do_reset();
    checks++;
    if ({cfg_done, tbl_valid, out_valid, out_f, in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL midload_reset: got %b expected 000000", {cfg_done, tbl_valid, out_valid, out_f, in_ready});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    proto_bad = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (tbl_valid !== 1'b0 || out_valid !== 1'b0 || proto_bad !== 0) begin
      errors++;
      $display("FAIL after_reset: tbl_valid %b out_valid %b deviations %0d expected 0 0 0",
               tbl_valid, out_valid, proto_bad);
    end
  endtask

`ifdef LUT_LOGIC_STATS_EN
  task automatic test_stats();
    load_bits({16'h6996, 16'h8000}, 0, 0);
    idle_ticks(2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    eval_all();
    checks++;
    if (ones_cnt[31:16] !== 16'd8 || ones_cnt[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL stats_count: got %0d %0d expected 8 1", ones_cnt[31:16], ones_cnt[15:0]);
    end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++;
    if (ones_cnt !== '0) begin
      errors++;
      $display("FAIL stats_clr: got %h expected 0", ones_cnt);
    end
    load_bits({16'hFFFF, 16'hFFFF}, 0, 0);
    idle_ticks(2);
    for (int k = 0; k < 65540; k++) begin
      in_valid  = 1'b1;
      in_x      = N_IN'(k);
      out_ready = 1'b1;
      tick();
      if (got_q.size() > 64) begin
        got_q.delete();
        exp_q.delete();
      end
    end
    idle_ticks(2);
    checks++;
    if (ones_cnt[31:16] !== 16'hFFFF || ones_cnt[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: got %h expected ffffffff", ones_cnt);
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    proto_bad = 0;
    done_seen = 0;
    test_reset();
    test_load_known();
    test_stream();
    test_reload_stream();
    test_idle_and_restart();
    test_random();
    test_reset_midload();
`ifdef LUT_LOGIC_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
